motor_ramp_ctrl: RTL and testbench
==================================

Name: motor_ramp_ctrl

Overview:
Two-channel motor command stage that sits directly upstream of the per-channel PWM generators and the H-bridge direction pins. It accepts signed speed commands through a valid/ready handshake and slews the duty toward each target at a fixed rate. On a direction reversal it ramps down to zero and inserts a dead time before flipping the direction pins. Outputs feed pwm duty/enable inputs and the bridge IN[3:0] pins directly.

Parameters:
DUTY_W, 8, duty width; must match the pwm duty input.
RAMP_DIV, 100000, clk cycles per ramp tick (one duty LSB step per tick); must be >= 1.
DEAD_CYCLES, 50000, clk cycles of coast between zero duty and the direction flip; must be >= 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid & ready
cmd_chan  in  1  0 = channel A, 1 = channel B
cmd_speed  in  DUTY_W+1  signed target speed; sign gives direction, magnitude gives duty
estop  in  1  emergency stop, level-sensitive
IN  out  4  bridge pins: [1:0] channel A, [3:2] channel B
duty_a  out  DUTY_W  duty to channel-A pwm
duty_b  out  DUTY_W  duty to channel-B pwm
en  out  2  pwm enables: bit0 = A, bit1 = B
busy  out  2  per channel: 1 while duty != |target| or in dead time

Behaviour:
- Reset: all duty = 0, IN = 0000, en = 00, busy = 00, targets = 0, dir = forward, state STOP, prescaler = 0. cmd_ready = 0 during reset, 1 from the first cycle after reset.
- cmd_ready = ~estop. On valid & ready, the addressed target register updates on that edge. Most-negative cmd_speed (-2^DUTY_W) clamps to -(2^DUTY_W - 1).
- Shared prescaler counts 0..RAMP_DIV-1 and pulses tick when it wraps. Both channels step only on tick, by at most 1 LSB.
- Per-channel FSM: STOP, RUN, DEAD.
  - STOP: duty = 0. A nonzero target goes to RUN. If the target sign differs from dir, go to DEAD first.
  - RUN, tick, target sign matches dir (or target = 0): duty steps toward |target|. If duty reaches 0 with target 0, go to STOP.
  - RUN, tick, sign differs and duty > 0: duty decrements. When duty == 0, go to DEAD.
  - DEAD: counter runs DEAD_CYCLES cycles and ignores tick. On expiry, dir takes the current target sign. Nonzero target goes to RUN, zero target goes to STOP.
  - A new command during DEAD updates the target but never shortens the dead time.
- IN per channel: forward = 2'b10, reverse = 2'b01, STOP/DEAD = 2'b00 (coast).
- en bit = (duty != 0). Outputs are registered; duty changes on the edge after the tick.
- Simultaneous command and tick on a channel: the step uses the old target; the new target applies from the next tick.
- estop high: next edge forces both duties to 0, IN = 0000, targets = 0, state STOP, dead counters cleared, no ramp. Commands are refused while high. After release, motion restarts only on new commands.
- Reset mid-ramp or mid-dead-time returns every output to its reset value on the next edge.

Optional Feature:
MOTOR_BRAKE_EN.
- Defined: STOP and DEAD drive 2'b11 per channel (active brake), and estop drives IN = 1111.
- Undefined: coast encoding 2'b00 everywhere, as above.

Decomposition:
- Package motor_pkg holds: direction enum (FWD, REV), state enum (STOP, RUN, DEAD), pin-encoding constants (PIN_FWD, PIN_REV, PIN_COAST, PIN_BRAKE), and the DUTY_W default.
- Sub-module motor_ramp_chan: one channel's FSM, duty register and dead counter. Instantiate it twice.
- The top level owns the handshake, command demux, shared prescaler and estop.

Test Plan:
Bench parameters: RAMP_DIV=4, DEAD_CYCLES=8.
1. Reset, then command A=+10 -> duty_a steps 1 per 4 clk and reaches 10 after 40 clk; IN[1:0]=10; en[0]=1; busy[0] falls when duty_a=10.
2. A at +10, command A=-5 -> duty_a ramps to 0 (40 clk), then IN[1:0]=00 for exactly 8 clk, then IN[1:0]=01 and duty_a ramps to 5.
3. A=+3 and B=-3 back-to-back commands -> channels ramp independently; duty_b=3 with IN[3:2]=01; cmd_ready stays 1 throughout.
4. Both channels at 20, assert estop 1 clk -> next edge duty_a=duty_b=0, IN=0000, en=00; a command offered during estop sees cmd_ready=0 and is dropped.
5. Command -256 -> clamped to -255: duty reaches 255 and never wraps.
6. Reset asserted during dead time -> all outputs equal reset values on the next edge. With MOTOR_BRAKE_EN, the same dead time shows IN[1:0]=11.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the two-channel motor ramp controller.
// Holds the direction and channel-state enums, the bridge pin encodings and
// the default duty width.
// Build option: MOTOR_BRAKE_EN selects active braking (2'b11) instead of
// coasting (2'b00) on an idle channel.
package motor_pkg;

   localparam int unsigned DUTY_W_DEFAULT = 8;

   typedef enum logic {
      FWD = 1'b0,
      REV = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_e;

   localparam logic [1:0] PIN_FWD   = 2'b10;
   localparam logic [1:0] PIN_REV   = 2'b01;
   localparam logic [1:0] PIN_COAST = 2'b00;
   localparam logic [1:0] PIN_BRAKE = 2'b11;

`ifdef MOTOR_BRAKE_EN
   localparam logic [1:0] PIN_IDLE = PIN_BRAKE;
`else
   localparam logic [1:0] PIN_IDLE = PIN_COAST;
`endif

   // Bridge pins for one channel: only RUN drives the bridge, everything else idles.
   function automatic logic [1:0] pin_code(input state_e s, input dir_e d);
      if (s == RUN) begin
         return (d == REV) ? PIN_REV : PIN_FWD;
      end
      return PIN_IDLE;
   endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: target register, STOP/RUN/DEAD state machine, duty
// register and dead-time counter.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   estop           forces duty/target to zero and the state to STOP
//   tick            shared ramp tick, one duty LSB step per tick
//   load, load_rev, load_mag   new target (sign, clamped magnitude)
//   duty            registered duty to the pwm
//   pins            registered bridge pins for this channel
//   busy            duty != |target| or dead time running
// Build option: MOTOR_BRAKE_EN (via motor_pkg) selects the idle pin code.
module motor_ramp_chan
   import motor_pkg::*;
#(
   parameter int unsigned DUTY_W      = DUTY_W_DEFAULT,
   parameter int unsigned DEAD_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              estop,
   input  logic              tick,
   input  logic              load,
   input  logic              load_rev,
   input  logic [DUTY_W-1:0] load_mag,
   output logic [DUTY_W-1:0] duty,
   output logic [1:0]        pins,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DEAD_CYCLES + 1);

   state_e              state_q, state_d;
   dir_e                dir_q, dir_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tgt_rev_q, tgt_rev_d;
   logic [DUTY_W-1:0]   tgt_mag_q, tgt_mag_d;
   logic [1:0]          pins_q, pins_d;

   logic tgt_zero;
   logic match;

   assign tgt_zero = (tgt_mag_q == '0);
   // A zero target counts as matching: the channel just ramps down to STOP.
   assign match    = tgt_zero || (tgt_rev_q == (dir_q == REV));

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      duty_d    = duty_q;
      cnt_d     = cnt_q;
      tgt_rev_d = tgt_rev_q;
      tgt_mag_d = tgt_mag_q;

      unique case (state_q)
         STOP: begin
            duty_d = '0;
            if (!tgt_zero) begin
               cnt_d   = '0;
               state_d = match ? RUN : DEAD;
            end
         end
         RUN: begin
            if (tick) begin
               if (match) begin
                  if (duty_q < tgt_mag_q) begin
                     duty_d = duty_q + DUTY_W'(1);
                  end else if (duty_q > tgt_mag_q) begin
                     duty_d = duty_q - DUTY_W'(1);
                  end
                  if (tgt_zero && duty_d == '0) begin
                     state_d = STOP;
                  end
               end else begin
                  // Reversal: ramp to zero before the dead time.
                  if (duty_q != '0) begin
                     duty_d = duty_q - DUTY_W'(1);
                  end
                  if (duty_d == '0) begin
                     state_d = DEAD;
                     cnt_d   = '0;
                  end
               end
            end
         end
         DEAD: begin
            // Full dead time always elapses; the target is only read on expiry.
            if (cnt_q == CNT_W'(DEAD_CYCLES - 1)) begin
               cnt_d   = '0;
               dir_d   = tgt_rev_q ? REV : FWD;
               state_d = tgt_zero ? STOP : RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = STOP;
      endcase

      // Target loads after the step so a same-edge tick still uses the old target.
      if (load) begin
         tgt_rev_d = load_rev;
         tgt_mag_d = load_mag;
      end

      if (estop) begin
         state_d   = STOP;
         duty_d    = '0;
         cnt_d     = '0;
         tgt_rev_d = 1'b0;
         tgt_mag_d = '0;
      end

      pins_d = pin_code(state_d, dir_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= STOP;
         dir_q     <= FWD;
         duty_q    <= '0;
         cnt_q     <= '0;
         tgt_rev_q <= 1'b0;
         tgt_mag_q <= '0;
         pins_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         duty_q    <= duty_d;
         cnt_q     <= cnt_d;
         tgt_rev_q <= tgt_rev_d;
         tgt_mag_q <= tgt_mag_d;
         pins_q    <= pins_d;
      end
   end

   assign duty = duty_q;
   assign pins = pins_q;
   assign busy = (duty_q != tgt_mag_q) || (state_q == DEAD);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-channel motor command stage: accepts signed speed commands over a
// valid/ready handshake, slews each channel's duty at one LSB per ramp tick
// and inserts a dead time on direction reversal.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready = not in reset, no estop)
//   cmd_chan              0 = channel A, 1 = channel B
//   cmd_speed             signed target; most-negative value clamps
//   estop                 level-sensitive emergency stop
//   IN                    bridge pins, [1:0] channel A, [3:2] channel B
//   duty_a, duty_b        pwm duties; en = duty != 0; busy per channel
// Build option: MOTOR_BRAKE_EN drives 2'b11 on idle channels instead of 2'b00.
module motor_ramp_ctrl
   import motor_pkg::*;
#(
   parameter int unsigned DUTY_W      = DUTY_W_DEFAULT,
   parameter int unsigned RAMP_DIV    = 100000,
   parameter int unsigned DEAD_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_chan,
   input  logic [DUTY_W:0]   cmd_speed,
   input  logic              estop,
   output logic [3:0]        IN,
   output logic [DUTY_W-1:0] duty_a,
   output logic [DUTY_W-1:0] duty_b,
   output logic [1:0]        en,
   output logic [1:0]        busy
);

   localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [PRE_W-1:0]  presc_q;
   logic              tick;
   logic              accept;
   logic              speed_rev;
   logic [DUTY_W:0]   speed_abs;
   logic [DUTY_W-1:0] speed_mag;
   logic [1:0]        pins_a, pins_b;
   logic              busy_a, busy_b;

   assign cmd_ready = ~reset & ~estop;
   assign accept    = cmd_valid & cmd_ready;

   // Only -2^DUTY_W overflows DUTY_W bits; saturate it to full scale.
   assign speed_rev = cmd_speed[DUTY_W];
   assign speed_abs = speed_rev ? (~cmd_speed + (DUTY_W + 1)'(1)) : cmd_speed;
   assign speed_mag = speed_abs[DUTY_W] ? '1 : speed_abs[DUTY_W-1:0];

   assign tick = (presc_q == PRE_W'(RAMP_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PRE_W'(1);
      end
   end

   motor_ramp_chan #(
      .DUTY_W      (DUTY_W),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_chan_a (
      .clk      (clk),
      .reset    (reset),
      .estop    (estop),
      .tick     (tick),
      .load     (accept & ~cmd_chan),
      .load_rev (speed_rev),
      .load_mag (speed_mag),
      .duty     (duty_a),
      .pins     (pins_a),
      .busy     (busy_a)
   );

   motor_ramp_chan #(
      .DUTY_W      (DUTY_W),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_chan_b (
      .clk      (clk),
      .reset    (reset),
      .estop    (estop),
      .tick     (tick),
      .load     (accept & cmd_chan),
      .load_rev (speed_rev),
      .load_mag (speed_mag),
      .duty     (duty_b),
      .pins     (pins_b),
      .busy     (busy_b)
   );

   assign IN   = {pins_b, pins_a};
   assign en   = {(duty_b != '0), (duty_a != '0)};
   assign busy = {busy_b, busy_a};

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: directed scenarios followed by
// randomized commands, estops and resets, all compared every cycle against
// a behavioural model of the channel rules. Honours MOTOR_BRAKE_EN.
module tb_motor_ramp_ctrl;

   localparam int DW = 8;
   localparam int RD = 4;
   localparam int DC = 8;
`ifdef MOTOR_BRAKE_EN
   localparam int IDLE = 3;
`else
   localparam int IDLE = 0;
`endif
   localparam int M_STOP = 0;
   localparam int M_RUN  = 1;
   localparam int M_DEAD = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_chan;
   logic [DW:0]   cmd_speed;
   logic          estop;
   logic [3:0]    IN;
   logic [DW-1:0] duty_a;
   logic [DW-1:0] duty_b;
   logic [1:0]    en;
   logic [1:0]    busy;

   motor_ramp_ctrl #(
      .DUTY_W      (DW),
      .RAMP_DIV    (RD),
      .DEAD_CYCLES (DC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_chan  (cmd_chan),
      .cmd_speed (cmd_speed),
      .estop     (estop),
      .IN        (IN),
      .duty_a    (duty_a),
      .duty_b    (duty_b),
      .en        (en),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: per-channel speed target, direction (0 fwd / 1 rev),
   // mode, dead-time cycles spent, duty and pin code.
   int m_duty[2];
   int m_tgt[2];
   int m_dir[2];
   int m_mode[2];
   int m_dead[2];
   int m_pins[2];
   int m_presc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_chan(input int ch, input bit tick);
      int  mag;
      bit  want_rev;
      mag      = iabs(m_tgt[ch]);
      want_rev = (m_tgt[ch] < 0);
      case (m_mode[ch])
         M_STOP: begin
            if (m_tgt[ch] != 0) begin
               m_dead[ch] = 0;
               m_mode[ch] = (int'(want_rev) == m_dir[ch]) ? M_RUN : M_DEAD;
            end
         end
         M_RUN: begin
            if (tick) begin
               if (m_tgt[ch] == 0 || int'(want_rev) == m_dir[ch]) begin
                  if (m_duty[ch] < mag) m_duty[ch]++;
                  else if (m_duty[ch] > mag) m_duty[ch]--;
                  if (m_tgt[ch] == 0 && m_duty[ch] == 0) m_mode[ch] = M_STOP;
               end else begin
                  if (m_duty[ch] > 0) m_duty[ch]--;
                  if (m_duty[ch] == 0) begin
                     m_mode[ch] = M_DEAD;
                     m_dead[ch] = 0;
                  end
               end
            end
         end
         default: begin
            m_dead[ch]++;
            if (m_dead[ch] == DC) begin
               m_dir[ch]  = int'(want_rev);
               m_mode[ch] = (m_tgt[ch] != 0) ? M_RUN : M_STOP;
            end
         end
      endcase
   endtask

   // Applies one clock edge to the model using the inputs present at that edge.
   task automatic model_edge();
      bit tick;
      int s;
      if (reset) begin
         m_presc = 0;
         for (int ch = 0; ch < 2; ch++) begin
            m_duty[ch] = 0; m_tgt[ch] = 0; m_dir[ch] = 0;
            m_mode[ch] = M_STOP; m_dead[ch] = 0; m_pins[ch] = 0;
         end
         return;
      end
      tick    = (m_presc == RD - 1);
      m_presc = tick ? 0 : m_presc + 1;
      for (int ch = 0; ch < 2; ch++) begin
         if (estop) begin
            m_duty[ch] = 0; m_tgt[ch] = 0; m_mode[ch] = M_STOP; m_dead[ch] = 0;
         end else begin
            model_chan(ch, tick);
            if (cmd_valid && int'(cmd_chan) == ch) begin
               s = $signed(cmd_speed);
               if (s < -255) s = -255;
               m_tgt[ch] = s;
            end
         end
         if (m_mode[ch] == M_RUN) m_pins[ch] = (m_dir[ch] != 0) ? 1 : 2;
         else m_pins[ch] = IDLE;
      end
   endtask

   task automatic compare_all();
      int exp_busy[2];
      for (int ch = 0; ch < 2; ch++) begin
         exp_busy[ch] = ((m_duty[ch] != iabs(m_tgt[ch])) || m_mode[ch] == M_DEAD) ? 1 : 0;
      end
      check_eq("duty_a", 32'(duty_a), m_duty[0]);
      check_eq("duty_b", 32'(duty_b), m_duty[1]);
      check_eq("IN", 32'(IN), (m_pins[1] << 2) | m_pins[0]);
      check_eq("en", 32'(en), ((m_duty[1] != 0) << 1) | (m_duty[0] != 0));
      check_eq("busy", 32'(busy), (exp_busy[1] << 1) | exp_busy[0]);
   endtask

   // One clock: check ready before the edge, update the model, check after it.
   task automatic step();
      #3;
      check_eq("cmd_ready", 32'(cmd_ready), (!reset && !estop) ? 1 : 0);
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic ch, input logic [DW:0] spd);
      cmd_valid = 1'b1;
      cmd_chan  = ch;
      cmd_speed = spd;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      int n;
      bit hit;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_chan  = 1'b0;
      cmd_speed = '0;
      estop     = 1'b0;
      m_presc   = 0;
      for (int ch = 0; ch < 2; ch++) begin
         m_duty[ch] = 0; m_tgt[ch] = 0; m_dir[ch] = 0;
         m_mode[ch] = M_STOP; m_dead[ch] = 0; m_pins[ch] = 0;
      end
      run(3);
      check_eq("rst_IN", 32'(IN), 0);
      check_eq("rst_duty_a", 32'(duty_a), 0);
      reset = 1'b0;

      // 1: ramp A to +10
      send(1'b0, 9'sd10);
      run(45);
      check_eq("t1_duty_a", 32'(duty_a), 10);
      check_eq("t1_in_a", 32'(IN[1:0]), 2);
      check_eq("t1_en_a", 32'(en[0]), 1);
      check_eq("t1_busy_a", 32'(busy[0]), 0);

      // 2: reverse A to -5, measure the dead time
      send(1'b0, -9'sd5);
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step();
         if (duty_a == 0) hit = 1;
      end
      check_eq("t2_reach_zero", 32'(hit), 1);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (IN[1:0] != 2'(IDLE)) break;
         n++;
      end
      check_eq("t2_dead_len", n, DC);
      check_eq("t2_in_rev", 32'(IN[1:0]), 1);
      run(30);
      check_eq("t2_duty_a", 32'(duty_a), 5);

      // 3: independent channels
      do_reset();
      send(1'b0, 9'sd3);
      send(1'b1, -9'sd3);
      run(40);
      check_eq("t3_duty_a", 32'(duty_a), 3);
      check_eq("t3_duty_b", 32'(duty_b), 3);
      check_eq("t3_in_b", 32'(IN[3:2]), 1);

      // 4: estop with both channels at 20
      send(1'b0, 9'sd20);
      send(1'b1, -9'sd20);
      run(100);
      check_eq("t4_pre_a", 32'(duty_a), 20);
      check_eq("t4_pre_b", 32'(duty_b), 20);
      estop     = 1'b1;
      cmd_valid = 1'b1;
      cmd_chan  = 1'b0;
      cmd_speed = 9'sd7;
      step();
      estop     = 1'b0;
      cmd_valid = 1'b0;
      check_eq("t4_duty_a", 32'(duty_a), 0);
      check_eq("t4_duty_b", 32'(duty_b), 0);
      check_eq("t4_IN", 32'(IN), (IDLE << 2) | IDLE);
      check_eq("t4_en", 32'(en), 0);
      run(20);
      check_eq("t4_dropped", 32'(duty_a), 0);

      // 5: most-negative speed clamps to -255
      do_reset();
      send(1'b0, 9'h100);
      run(1060);
      check_eq("t5_duty_a", 32'(duty_a), 255);
      check_eq("t5_in_a", 32'(IN[1:0]), 1);
      run(40);
      check_eq("t5_hold", 32'(duty_a), 255);

      // 6: reset during dead time
      do_reset();
      send(1'b0, 9'sd5);
      run(30);
      send(1'b0, -9'sd5);
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step();
         if (duty_a == 0) hit = 1;
      end
      run(2);
      check_eq("t6_dead_pins", 32'(IN[1:0]), IDLE);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("t6_IN", 32'(IN), 0);
      check_eq("t6_duty_a", 32'(duty_a), 0);
      check_eq("t6_en", 32'(en), 0);
      check_eq("t6_busy", 32'(busy), 0);

      // Randomized phase
      for (int i = 0; i < 4000; i++) begin
         cmd_valid = ($urandom_range(11) == 0);
         cmd_chan  = 1'($urandom_range(1));
         case ($urandom_range(7))
            0:       cmd_speed = 9'h100;
            1:       cmd_speed = 9'($urandom_range(511));
            2:       cmd_speed = '0;
            default: cmd_speed = 9'($urandom_range(24)) - 9'd12;
         endcase
         estop = ($urandom_range(299) == 0);
         reset = ($urandom_range(799) == 0);
         step();
      end
      cmd_valid = 1'b0;
      estop     = 1'b0;
      reset     = 1'b0;
      run(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
